// File: rtl/game_pkg.sv
// Shared encodings for the game screen sequencer and its overlays.
package game_pkg;

  // Committed screen / FSM state encodings.
  typedef enum logic [2:0] {
    ScrMenu   = 3'd0,
    ScrStage1 = 3'd1,
    ScrDie1   = 3'd2,
    ScrClear1 = 3'd3,
    ScrStage2 = 3'd4,
    ScrDie2   = 3'd5,
    ScrWin    = 3'd6
  } screen_e;

  // One-cycle key codes from the keyboard front end.
  localparam logic [4:0] KeyMove = 5'h1e;
  localparam logic [4:0] KeySel  = 5'h1d;

  // Overlay selection codes.
  localparam logic [1:0] SelStart   = 2'b00;
  localparam logic [1:0] SelRestart = 2'b00;
  localparam logic [1:0] SelMenu    = 2'b01;
  localparam logic [1:0] SelNone    = 2'b11;

  // Entering either playable stage requires the game logic to reset.
  function automatic logic is_stage(screen_e s);
    return (s == ScrStage1) || (s == ScrStage2);
  endfunction

  // Encoding 7 is unused and must recover to the menu.
  function automatic logic screen_valid(logic [2:0] s);
    return s <= 3'd6;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Single-cycle per-frame pulse at a fixed (x, y) position.
// The raw match lasts a whole pixel (several clocks), so only its rising edge is reported.
module frame_tick #(
  parameter int unsigned FRAME_X = 0,
  parameter int unsigned FRAME_Y = 480
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_tick
);

  logic w_match;
  logic r_match;
  logic r_match_d;

  assign w_match = (i_x == 10'(FRAME_X)) && (i_y == 10'(FRAME_Y));

  // Register the raw match and keep one cycle of history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_match_d <= r_match;
    end
  end

  assign o_tick = r_match & ~r_match_d;

endmodule

// File: rtl/game_screen_ctrl.sv
// Top-level screen sequencer: latches screen-change requests and commits them at a
// frame boundary, drives the rgb mux and the stage-reset pulse.
module game_screen_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAME_X      = 0,
  parameter int unsigned FRAME_Y      = 480,
  parameter int unsigned CLEAR_FRAMES = 120
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [4:0] i_key_pulse,
  input  logic [1:0] i_menu_sel,
  input  logic [1:0] i_die1_sel,
  input  logic [1:0] i_die2_sel,
  input  logic       i_die_evt,
  input  logic       i_clr_evt,
  input  logic [2:0] i_rgb_menu,
  input  logic [2:0] i_rgb_st1,
  input  logic [2:0] i_rgb_die1,
  input  logic [2:0] i_rgb_clr,
  input  logic [2:0] i_rgb_st2,
  input  logic [2:0] i_rgb_die2,
  input  logic [2:0] i_rgb_win,
  output logic [2:0] o_rgb,
  output logic [2:0] o_screen,
  output logic       o_stage_rst,
  output logic       o_pend
);

  localparam int unsigned CntW = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLEAR_FRAMES - 1);

  logic            w_tick;
  logic            w_req;
  screen_e         w_req_tgt;
  screen_e         r_screen;
  screen_e         r_target;
  logic            r_pend;
  logic            r_stage_rst;
  logic [CntW-1:0] r_clr_cnt;

  frame_tick #(
    .FRAME_X (FRAME_X),
    .FRAME_Y (FRAME_Y)
  ) u_frame_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_x    (i_x),
    .i_y    (i_y),
    .o_tick (w_tick)
  );

  // Decode a transition request from the committed screen and this cycle's inputs.
  always_comb begin
    w_req     = 1'b0;
    w_req_tgt = ScrMenu;
    case (r_screen)
      ScrMenu: begin
        if (i_menu_sel == SelStart) begin
          w_req     = 1'b1;
          w_req_tgt = ScrStage1;
        end
      end
      ScrStage1: begin
        // Death beats a same-cycle clear.
        if (i_die_evt) begin
          w_req     = 1'b1;
          w_req_tgt = ScrDie1;
        end else if (i_clr_evt) begin
          w_req     = 1'b1;
          w_req_tgt = ScrClear1;
        end
      end
      ScrDie1: begin
        if (i_die1_sel == SelRestart) begin
          w_req     = 1'b1;
          w_req_tgt = ScrStage1;
        end else if (i_die1_sel == SelMenu) begin
          w_req     = 1'b1;
          w_req_tgt = ScrMenu;
        end
      end
      ScrClear1: begin
        if ((i_key_pulse == KeySel) || (w_tick && (r_clr_cnt == CntMax))) begin
          w_req     = 1'b1;
          w_req_tgt = ScrStage2;
        end
      end
      ScrStage2: begin
        if (i_die_evt) begin
          w_req     = 1'b1;
          w_req_tgt = ScrDie2;
        end else if (i_clr_evt) begin
          w_req     = 1'b1;
          w_req_tgt = ScrWin;
        end
      end
      ScrDie2: begin
        if (i_die2_sel == SelRestart) begin
          w_req     = 1'b1;
          w_req_tgt = ScrStage2;
        end else if (i_die2_sel == SelMenu) begin
          w_req     = 1'b1;
          w_req_tgt = ScrMenu;
        end
      end
      ScrWin: begin
        if (i_key_pulse == KeySel) begin
          w_req     = 1'b1;
          w_req_tgt = ScrMenu;
        end
      end
      default: ;
    endcase
  end

  // Screen FSM: latch first request, commit it on the next frame tick.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_screen    <= ScrMenu;
      r_target    <= ScrMenu;
      r_pend      <= 1'b0;
      r_stage_rst <= 1'b0;
      r_clr_cnt   <= '0;
    end else begin
      r_stage_rst <= 1'b0;
      if (w_tick && r_pend) begin
        r_screen    <= r_target;
        r_pend      <= 1'b0;
        r_stage_rst <= is_stage(r_target);
        if (r_target == ScrClear1) begin
          r_clr_cnt <= '0;
        end
      end else begin
        if (w_tick) begin
          if ((r_screen == ScrClear1) && (r_clr_cnt != CntMax)) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
          if (!screen_valid(r_screen)) begin
            r_screen <= ScrMenu;
          end
        end
        // A request seen on a tick cycle still waits for the following tick.
        if (!r_pend && w_req) begin
          r_pend   <= 1'b1;
          r_target <= w_req_tgt;
        end
      end
    end
  end

  // Pixel colour follows the committed screen only.
  always_comb begin
    o_rgb = 3'b000;
    case (r_screen)
      ScrMenu:   o_rgb = i_rgb_menu;
      ScrStage1: o_rgb = i_rgb_st1;
      ScrDie1:   o_rgb = i_rgb_die1;
      ScrClear1: o_rgb = i_rgb_clr;
      ScrStage2: o_rgb = i_rgb_st2;
      ScrDie2:   o_rgb = i_rgb_die2;
      ScrWin:    o_rgb = i_rgb_win;
      default:   o_rgb = 3'b000;
    endcase
  end

  assign o_screen    = r_screen;
  assign o_pend      = r_pend;
  assign o_stage_rst = r_stage_rst;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Randomized bench for game_screen_ctrl against a transition-table reference model.
module tb_game_screen_ctrl;

  localparam int unsigned FX = 0;
  localparam int unsigned FY = 4;
  localparam int unsigned CF = 3;
  localparam int          NumIter = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic [4:0] key;
  logic [1:0] msel;
  logic [1:0] d1sel;
  logic [1:0] d2sel;
  logic       die_evt;
  logic       clr_evt;
  logic [2:0] rgb_in [7];
  logic [2:0] rgb;
  logic [2:0] screen;
  logic       stage_rst;
  logic       pend;

  always #5 clk = ~clk;

  game_screen_ctrl #(
    .FRAME_X      (FX),
    .FRAME_Y      (FY),
    .CLEAR_FRAMES (CF)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_x         (x),
    .i_y         (y),
    .i_key_pulse (key),
    .i_menu_sel  (msel),
    .i_die1_sel  (d1sel),
    .i_die2_sel  (d2sel),
    .i_die_evt   (die_evt),
    .i_clr_evt   (clr_evt),
    .i_rgb_menu  (rgb_in[0]),
    .i_rgb_st1   (rgb_in[1]),
    .i_rgb_die1  (rgb_in[2]),
    .i_rgb_clr   (rgb_in[3]),
    .i_rgb_st2   (rgb_in[4]),
    .i_rgb_die2  (rgb_in[5]),
    .i_rgb_win   (rgb_in[6]),
    .o_rgb       (rgb),
    .o_screen    (screen),
    .o_stage_rst (stage_rst),
    .o_pend      (pend)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: screen number, queue of at most one pending target,
  // frames spent in CLEAR1, and match history giving the frame tick.
  int m_scr;
  int m_pend_q[$];
  bit m_srst;
  int m_frames;
  bit m_match1;
  bit m_match2;

  task automatic model_reset();
    m_scr    = 0;
    m_pend_q = {};
    m_srst   = 1'b0;
    m_frames = 0;
    m_match1 = 1'b0;
    m_match2 = 1'b0;
  endtask

  // Transition table: target screen for a request, or -1 for none.
  function automatic int want(int scr, bit auto_adv);
    case (scr)
      0: return (msel == 2'b00) ? 1 : -1;
      1: return die_evt ? 2 : (clr_evt ? 3 : -1);
      2: return (d1sel == 2'b00) ? 1 : ((d1sel == 2'b01) ? 0 : -1);
      3: return ((key == 5'h1d) || auto_adv) ? 4 : -1;
      4: return die_evt ? 5 : (clr_evt ? 6 : -1);
      5: return (d2sel == 2'b00) ? 4 : ((d2sel == 2'b01) ? 0 : -1);
      6: return (key == 5'h1d) ? 0 : -1;
      default: return 0;
    endcase
  endfunction

  // Advance the model across one rising clock edge using the inputs now applied.
  task automatic model_step();
    bit tick;
    bit auto_adv;
    int t;
    if (!rst) begin
      model_reset();
      return;
    end
    tick     = m_match1 && !m_match2;
    m_match2 = m_match1;
    m_match1 = (x == 10'(FX)) && (y == 10'(FY));
    m_srst   = 1'b0;
    if (tick && m_pend_q.size() > 0) begin
      m_scr  = m_pend_q.pop_front();
      m_srst = (m_scr == 1) || (m_scr == 4);
      if (m_scr == 3) m_frames = 0;
    end else begin
      auto_adv = tick && (m_scr == 3) && (m_frames == int'(CF) - 1);
      if (tick && m_scr == 3) m_frames++;
      if (m_pend_q.size() == 0) begin
        t = want(m_scr, auto_adv);
        if (t >= 0) m_pend_q.push_back(t);
      end
    end
  endtask

  int pc;

  task automatic drive_random();
    pc++;
    x = 10'((pc / 2) % 8);
    y = 10'((pc / 16) % 6);
    key     = ($urandom_range(0, 199) == 0) ? 5'h1d :
              (($urandom_range(0, 29) == 0) ? 5'h1e : 5'(($urandom_range(0, 28))));
    msel    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    d1sel   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    d2sel   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    die_evt = ($urandom_range(0, 59) == 0);
    clr_evt = ($urandom_range(0, 39) == 0);
    for (int k = 0; k < 7; k++) rgb_in[k] = 3'($urandom);
  endtask

  initial begin
    int rst_hold;
    bit rst_want;
    int rst_wait;
    rst = 1'b0;
    pc  = 0;
    drive_random();
    model_reset();
    rst_hold = 3;
    rst_want = 1'b0;
    rst_wait = 0;
    for (int i = 0; i < NumIter; i++) begin
      model_step();
      @(posedge clk);
      #1;
      check_eq("screen", int'(screen), m_scr);
      check_eq("pend", int'(pend), (m_pend_q.size() > 0) ? 1 : 0);
      check_eq("stage_rst", int'(stage_rst), int'(m_srst));
      drive_random();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else begin
        if (i % 4000 == 3999) begin
          rst_want = 1'b1;
          rst_wait = 0;
        end
        if (rst_want) rst_wait++;
        // Prefer hitting reset while a transition is pending.
        if (rst_want && (m_pend_q.size() > 0 || rst_wait > 600)) begin
          rst_want = 1'b0;
          rst      = 1'b0;
          rst_hold = 3;
          model_reset();
          #1;
          check_eq("async_rst_screen", int'(screen), 0);
          check_eq("async_rst_pend", int'(pend), 0);
          check_eq("async_rst_stage_rst", int'(stage_rst), 0);
        end
      end
      #1;
      check_eq("rgb", int'(rgb), int'(rgb_in[m_scr]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_screen_ctrl.md
Name: game_screen_ctrl

Overview:
- Top-level screen sequencer for the two-stage game.
- Owns the game-state FSM: MENU, STAGE1, DIE1, CLEAR1, STAGE2, DIE2, WIN.
- Consumes selection codes from the menu and die overlays, plus event pulses from the game logic.
- Selects which screen's rgb drives the VGA output, and issues stage-reset pulses to the game logic.
- State changes are committed only at a frame boundary, so no frame ever shows two screens.

Parameters:
- FRAME_X, 0, x value of the commit point.
- FRAME_Y, 480, y value of the commit point (first vblank line).
- CLEAR_FRAMES, 120, number of frames CLEAR1 is shown before auto-advancing to STAGE2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- key_pulse  in  5  one-cycle key code: 5'h1e = move, 5'h1d = select, other values = none.
- menu_sel  in  2  menu overlay choice: 00 = start, 11 = none, others ignored.
- die1_sel  in  2  stage-1 die overlay: 00 = restart, 01 = menu, 11 = none.
- die2_sel  in  2  stage-2 die overlay: same encoding as die1_sel.
- die_evt  in  1  one-cycle pulse: player died.
- clr_evt  in  1  one-cycle pulse: current stage cleared.
- rgb_menu, rgb_st1, rgb_die1, rgb_clr, rgb_st2, rgb_die2, rgb_win  in  3 each  per-screen pixel colour.
- rgb  out  3  selected pixel colour.
- screen  out  3  current committed state encoding.
- stage_rst  out  1  one-cycle pulse when entering STAGE1 or STAGE2.
- pend  out  1  a transition is latched and waiting for commit.

Behaviour:
- Reset (rst=0): screen=MENU, pend=0, stage_rst=0, clear counter=0. rgb follows rgb_menu combinationally.
- Frame tick:
  - Raw match is x==FRAME_X && y==FRAME_Y.
  - tick is a single-cycle pulse on the rising edge of the raw match, since the match holds for several clk cycles per pixel.
- Request rules (evaluated every cycle, only while pend=0):
  - MENU: menu_sel==00 -> STAGE1.
  - STAGE1: die_evt -> DIE1; else clr_evt -> CLEAR1.
  - DIE1: die1_sel==00 -> STAGE1; die1_sel==01 -> MENU.
  - CLEAR1: key_pulse==5'h1d, or clear counter==CLEAR_FRAMES-1 at a tick -> STAGE2.
  - STAGE2: die_evt -> DIE2; else clr_evt -> WIN.
  - DIE2: die2_sel==00 -> STAGE2; die2_sel==01 -> MENU.
  - WIN: key_pulse==5'h1d -> MENU.
- Precedence and latching:
  - die_evt and clr_evt in the same cycle: die wins.
  - The request latches into the pending-target register and sets pend=1.
  - While pend=1, further requests are ignored (first request wins).
- Commit:
  - On tick with pend=1: screen <= target, pend <= 0.
  - stage_rst=1 for exactly that cycle if the target is STAGE1 or STAGE2, including a restart into the same stage.
- Same-cycle request and tick: the request is latched that cycle and commits at the next tick, never in the same cycle.
- Clear counter:
  - Cleared on commit into CLEAR1.
  - Increments on each tick while screen==CLEAR1; saturates.
  - The auto-advance request is raised at the tick where the count equals CLEAR_FRAMES-1.
- rgb is a combinational mux on the committed screen only; pend has no effect on rgb.
- Unused state encodings recover to MENU at the next tick.
- Reset asserted mid-operation: all state returns to reset values immediately and any pending transition is discarded.

Decomposition:
- Shared package game_pkg:
  - State encodings MENU=0, STAGE1=1, DIE1=2, CLEAR1=3, STAGE2=4, DIE2=5, WIN=6.
  - Key codes KEY_MOVE=5'h1e, KEY_SEL=5'h1d.
  - Selection codes SEL_START/SEL_RESTART=2'b00, SEL_MENU=2'b01, SEL_NONE=2'b11.
- Sub-module frame_tick: x, y, FRAME_X/FRAME_Y parameters -> single-cycle tick (registered match plus edge detect). It is reused by other overlays that need per-frame timing.

Test Plan:
- Reset with rst=0, then release; menu_sel=00 mid-frame -> pend=1 and screen=0 until the tick; at the tick screen=1, stage_rst=1 for one cycle, rgb==rgb_st1.
- In STAGE1, die_evt and clr_evt in the same cycle -> next commit screen=2 (DIE1); die1_sel=01 -> screen=0 after the following tick, with no stage_rst.
- In DIE1, die1_sel=00 -> screen=1 and a stage_rst pulse; die1_sel=01 in the following cycle while pend=1 is ignored.
- In CLEAR1 with CLEAR_FRAMES=3 and no keys -> pend rises at the 3rd tick and screen=4 at the 4th tick; repeat with key_pulse=5'h1d at frame 1 -> screen=4 at the next tick.
- In STAGE2: clr_evt -> screen=6; key_pulse=5'h1e -> no change; key_pulse=5'h1d -> screen=0.
- rst=0 asserted while pend=1 toward STAGE2 -> screen=0, pend=0 at once; no stage_rst after release until a new request.
